// File: rtl/axi_addr_router.sv
// axi_addr_router: one upstream AXI4 master fanned out to AXI_SLAVE_PORT
// downstream ports by the top address bits. Unmapped regions get DECERR
// from an internal responder. One write and one read may be outstanding
// at a time, and the two directions are independent.
module axi_addr_router #(
   parameter int AXI_ID_WIDTH   = 1,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 8,
   parameter int AXI_SLAVE_PORT = 3,
   parameter int SEL_WIDTH      = 2,
   localparam int STRB_W = AXI_DATA_WIDTH / 8,
   localparam int AW_W   = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
   localparam int W_W    = AXI_DATA_WIDTH + STRB_W + 1,
   localparam int B_W    = AXI_ID_WIDTH + 2,
   localparam int R_W    = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [AXI_ID_WIDTH-1:0]           S_AXI_AWID,
   input  logic [AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
   input  logic [7:0]                        S_AXI_AWLEN,
   input  logic [2:0]                        S_AXI_AWSIZE,
   input  logic [1:0]                        S_AXI_AWBURST,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
   input  logic [STRB_W-1:0]                 S_AXI_WSTRB,
   input  logic                              S_AXI_WLAST,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [AXI_ID_WIDTH-1:0]           S_AXI_BID,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [AXI_ID_WIDTH-1:0]           S_AXI_ARID,
   input  logic [AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
   input  logic [7:0]                        S_AXI_ARLEN,
   input  logic [2:0]                        S_AXI_ARSIZE,
   input  logic [1:0]                        S_AXI_ARBURST,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [AXI_ID_WIDTH-1:0]           S_AXI_RID,
   output logic [AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RLAST,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [AXI_SLAVE_PORT*AW_W-1:0]    M_AXI_AWCH_o,
   output logic [AXI_SLAVE_PORT-1:0]         M_AXI_AWCH_VALID_o,
   input  logic [AXI_SLAVE_PORT-1:0]         M_AXI_AWCH_READY_i,
   output logic [AXI_SLAVE_PORT*W_W-1:0]     M_AXI_WCH_o,
   output logic [AXI_SLAVE_PORT-1:0]         M_AXI_WCH_VALID_o,
   input  logic [AXI_SLAVE_PORT-1:0]         M_AXI_WCH_READY_i,
   input  logic [AXI_SLAVE_PORT*B_W-1:0]     M_AXI_BCH_i,
   input  logic [AXI_SLAVE_PORT-1:0]         M_AXI_BCH_VALID_i,
   output logic [AXI_SLAVE_PORT-1:0]         M_AXI_BCH_READY_o,
   output logic [AXI_SLAVE_PORT*AW_W-1:0]    M_AXI_ARCH_o,
   output logic [AXI_SLAVE_PORT-1:0]         M_AXI_ARCH_VALID_o,
   input  logic [AXI_SLAVE_PORT-1:0]         M_AXI_ARCH_READY_i,
   input  logic [AXI_SLAVE_PORT*R_W-1:0]     M_AXI_RCH_i,
   input  logic [AXI_SLAVE_PORT-1:0]         M_AXI_RCH_VALID_i,
   output logic [AXI_SLAVE_PORT-1:0]         M_AXI_RCH_READY_o
);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_FWD  = 2'd1;
   localparam logic [1:0] R_ERR  = 2'd2;

   logic [1:0]                wstate_q, wstate_d;
   logic [SEL_WIDTH-1:0]      wtgt_q, wtgt_d;
   logic                      werr_q, werr_d;
   logic [AXI_ID_WIDTH-1:0]   awid_q, awid_d;

   logic [1:0]                rstate_q, rstate_d;
   logic [SEL_WIDTH-1:0]      rtgt_q, rtgt_d;
   logic [AXI_ID_WIDTH-1:0]   arid_q, arid_d;
   logic [7:0]                arlen_q, arlen_d;
   logic [7:0]                beat_cnt_q, beat_cnt_d;

   logic [SEL_WIDTH-1:0]      aw_tgt, ar_tgt;
   logic                      aw_mapped, ar_mapped;

   assign aw_tgt    = S_AXI_AWADDR[AXI_ADDR_WIDTH-1 -: SEL_WIDTH];
   assign ar_tgt    = S_AXI_ARADDR[AXI_ADDR_WIDTH-1 -: SEL_WIDTH];
   assign aw_mapped = (32'(aw_tgt) < AXI_SLAVE_PORT);
   assign ar_mapped = (32'(ar_tgt) < AXI_SLAVE_PORT);

   // Payload buses are broadcast to every port; only VALID/READY are steered.
   assign M_AXI_AWCH_o = {AXI_SLAVE_PORT{{S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE,
                                          S_AXI_AWBURST, S_AXI_AWADDR}}};
   assign M_AXI_ARCH_o = {AXI_SLAVE_PORT{{S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE,
                                          S_AXI_ARBURST, S_AXI_ARADDR}}};
   assign M_AXI_WCH_o  = {AXI_SLAVE_PORT{{S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST}}};

   // Write path: AW/W/B steering, internal DECERR responder, next-state logic.
   always_comb begin
      wstate_d           = wstate_q;
      wtgt_d             = wtgt_q;
      werr_d             = werr_q;
      awid_d             = awid_q;
      S_AXI_AWREADY      = 1'b0;
      S_AXI_WREADY       = 1'b0;
      S_AXI_BVALID       = 1'b0;
      S_AXI_BID          = '0;
      S_AXI_BRESP        = 2'b00;
      M_AXI_AWCH_VALID_o = '0;
      M_AXI_WCH_VALID_o  = '0;
      M_AXI_BCH_READY_o  = '0;
      case (wstate_q)
         W_IDLE: begin
            if (aw_mapped) begin
               for (int k = 0; k < AXI_SLAVE_PORT; k++) begin
                  if (aw_tgt == SEL_WIDTH'(k)) begin
                     M_AXI_AWCH_VALID_o[k] = S_AXI_AWVALID;
                     S_AXI_AWREADY         = M_AXI_AWCH_READY_i[k];
                  end
               end
            end else begin
               S_AXI_AWREADY = 1'b1;
            end
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
               wtgt_d   = aw_tgt;
               werr_d   = !aw_mapped;
               awid_d   = S_AXI_AWID;
               wstate_d = W_DATA;
            end
         end
         W_DATA: begin
            if (!werr_q) begin
               for (int k = 0; k < AXI_SLAVE_PORT; k++) begin
                  if (wtgt_q == SEL_WIDTH'(k)) begin
                     M_AXI_WCH_VALID_o[k] = S_AXI_WVALID;
                     S_AXI_WREADY         = M_AXI_WCH_READY_i[k];
                  end
               end
            end else begin
               S_AXI_WREADY = 1'b1;
            end
            if (S_AXI_WVALID && S_AXI_WREADY && S_AXI_WLAST) begin
               wstate_d = W_RESP;
            end
         end
         W_RESP: begin
            if (!werr_q) begin
               for (int k = 0; k < AXI_SLAVE_PORT; k++) begin
                  if (wtgt_q == SEL_WIDTH'(k)) begin
                     S_AXI_BVALID         = M_AXI_BCH_VALID_i[k];
                     S_AXI_BID            = M_AXI_BCH_i[k*B_W +: AXI_ID_WIDTH];
                     S_AXI_BRESP          = M_AXI_BCH_i[k*B_W + AXI_ID_WIDTH +: 2];
                     M_AXI_BCH_READY_o[k] = S_AXI_BREADY;
                  end
               end
            end else begin
               S_AXI_BVALID = 1'b1;
               S_AXI_BID    = awid_q;
               S_AXI_BRESP  = 2'b11;
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
               wstate_d = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
      if (!ARESETN) begin
         S_AXI_AWREADY      = 1'b0;
         S_AXI_WREADY       = 1'b0;
         S_AXI_BVALID       = 1'b0;
         M_AXI_AWCH_VALID_o = '0;
         M_AXI_WCH_VALID_o  = '0;
         M_AXI_BCH_READY_o  = '0;
      end
   end

   // Read path: AR/R steering, DECERR burst generator, next-state logic.
   always_comb begin
      rstate_d           = rstate_q;
      rtgt_d             = rtgt_q;
      arid_d             = arid_q;
      arlen_d            = arlen_q;
      beat_cnt_d         = beat_cnt_q;
      S_AXI_ARREADY      = 1'b0;
      S_AXI_RVALID       = 1'b0;
      S_AXI_RID          = '0;
      S_AXI_RDATA        = '0;
      S_AXI_RRESP        = 2'b00;
      S_AXI_RLAST        = 1'b0;
      M_AXI_ARCH_VALID_o = '0;
      M_AXI_RCH_READY_o  = '0;
      case (rstate_q)
         R_IDLE: begin
            if (ar_mapped) begin
               for (int k = 0; k < AXI_SLAVE_PORT; k++) begin
                  if (ar_tgt == SEL_WIDTH'(k)) begin
                     M_AXI_ARCH_VALID_o[k] = S_AXI_ARVALID;
                     S_AXI_ARREADY         = M_AXI_ARCH_READY_i[k];
                  end
               end
            end else begin
               S_AXI_ARREADY = 1'b1;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
               rtgt_d     = ar_tgt;
               arid_d     = S_AXI_ARID;
               arlen_d    = S_AXI_ARLEN;
               beat_cnt_d = 8'd0;
               rstate_d   = ar_mapped ? R_FWD : R_ERR;
            end
         end
         R_FWD: begin
            for (int k = 0; k < AXI_SLAVE_PORT; k++) begin
               if (rtgt_q == SEL_WIDTH'(k)) begin
                  S_AXI_RVALID         = M_AXI_RCH_VALID_i[k];
                  S_AXI_RID            = M_AXI_RCH_i[k*R_W +: AXI_ID_WIDTH];
                  S_AXI_RLAST          = M_AXI_RCH_i[k*R_W + AXI_ID_WIDTH];
                  S_AXI_RRESP          = M_AXI_RCH_i[k*R_W + AXI_ID_WIDTH + 1 +: 2];
                  S_AXI_RDATA          = M_AXI_RCH_i[k*R_W + AXI_ID_WIDTH + 3 +: AXI_DATA_WIDTH];
                  M_AXI_RCH_READY_o[k] = S_AXI_RREADY;
               end
            end
            if (S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST) begin
               rstate_d = R_IDLE;
            end
         end
         R_ERR: begin
            S_AXI_RVALID = 1'b1;
            S_AXI_RID    = arid_q;
            S_AXI_RRESP  = 2'b11;
            S_AXI_RLAST  = (beat_cnt_q == arlen_q);
            if (S_AXI_RREADY) begin
               if (S_AXI_RLAST) begin
                  rstate_d = R_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
      if (!ARESETN) begin
         S_AXI_ARREADY      = 1'b0;
         S_AXI_RVALID       = 1'b0;
         M_AXI_ARCH_VALID_o = '0;
         M_AXI_RCH_READY_o  = '0;
      end
   end

   // State, target, ID and beat-count registers for both directions.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wstate_q   <= W_IDLE;
         wtgt_q     <= '0;
         werr_q     <= 1'b0;
         awid_q     <= '0;
         rstate_q   <= R_IDLE;
         rtgt_q     <= '0;
         arid_q     <= '0;
         arlen_q    <= 8'd0;
         beat_cnt_q <= 8'd0;
      end else begin
         wstate_q   <= wstate_d;
         wtgt_q     <= wtgt_d;
         werr_q     <= werr_d;
         awid_q     <= awid_d;
         rstate_q   <= rstate_d;
         rtgt_q     <= rtgt_d;
         arid_q     <= arid_d;
         arlen_q    <= arlen_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule
